// File: rtl/hsdaoh_pkg.sv
// hsdaoh_pkg: shared encodings and constants for the FIFO test-pattern source.
// Revision 1.0
`default_nettype none

package hsdaoh_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_CONST   = 2'd2,
    MODE_ALT     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1 -> taps on bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] ALT_WORD0 = 16'h5555;
  localparam logic [15:0] ALT_WORD1 = 16'hAAAA;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hsdaoh_lfsr16.sv
// hsdaoh_lfsr16: 16-bit Fibonacci LFSR, shift left, feedback into bit 0.
// Revision 1.0
`default_nettype none

module hsdaoh_lfsr16
  import hsdaoh_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_test_source.sv
// fifo_test_source: free-running pattern generator feeding a FIFO, with drop accounting.
// Revision 1.0
`default_nettype none

module fifo_test_source
  import hsdaoh_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_data,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_word,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_wr_en,
  output logic [15:0]           drop_count,
  output logic                  overflow,
  output logic                  busy
);

  state_e                state;
  state_e                state_next;
  logic                  active;
  logic                  start;
  logic [15:0]           counter;
  logic                  phase;
  logic [15:0]           lfsr_q;
  logic [DATA_WIDTH-1:0] word;

  assign active = (state != ST_IDLE);
  assign start  = (state == ST_IDLE) && enable;
  assign busy   = active;

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable) state_next = ST_RUN;
      ST_RUN:   if (!enable) state_next = ST_IDLE;
                else if (fifo_full) state_next = ST_STALL;
      ST_STALL: if (!enable) state_next = ST_IDLE;
                else if (!fifo_full) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  // All generators run every active cycle so a mode switch never needs a reload.
  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      counter <= 16'h0000;
      phase   <= 1'b0;
    end else if (start) begin
      counter <= 16'h0000;
      phase   <= 1'b0;
    end else if (active) begin
      counter <= counter + 16'd1;
      phase   <= ~phase;
    end
  end

  hsdaoh_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk     (clk_data),
    .rst     (rst),
    .load    (start),
    .advance (active),
    .q       (lfsr_q)
  );

  always_comb begin
    word = DATA_WIDTH'(counter);
    case (mode_e'(mode))
      MODE_COUNTER: word = DATA_WIDTH'(counter);
      MODE_LFSR:    word = DATA_WIDTH'(lfsr_q);
      MODE_CONST:   word = const_word;
      default:      word = DATA_WIDTH'(phase ? ALT_WORD1 : ALT_WORD0);
    endcase
  end

  always_ff @(posedge clk_data or posedge rst) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      drop_count <= 16'h0000;
      overflow   <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (active) begin
        if (fifo_full) begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
        end else begin
          fifo_wr_en <= 1'b1;
          fifo_wdata <= word;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_test_source.sv
// tb_fifo_test_source: vector table, directed corner sequences and randomized model comparison.
// Revision 1.0
`default_nettype none

module tb_fifo_test_source;

  localparam int          DW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk_data   = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic [1:0]    mode       = 2'd0;
  logic [DW-1:0] const_word = '0;
  logic          fifo_full  = 1'b0;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wr_en;
  logic [15:0]   drop_count;
  logic          overflow;
  logic          busy;

  fifo_test_source #(
    .DATA_WIDTH (DW),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk_data   (clk_data),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .const_word (const_word),
    .fifo_full  (fifo_full),
    .fifo_wdata (fifo_wdata),
    .fifo_wr_en (fifo_wr_en),
    .drop_count (drop_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk_data = ~clk_data;

  int checks = 0;
  int errors = 0;

  // Reference model: a running flag plus the three generator values.
  bit          m_run;
  bit          m_ph;
  bit          m_ovf;
  bit          m_wr;
  logic [15:0] m_cnt;
  logic [15:0] m_lfsr;
  logic [15:0] m_drop;
  logic [15:0] m_data;

  typedef struct {
    logic        en;
    logic        full;
    logic        exp_wr;
    logic [15:0] exp_data;
    logic [15:0] exp_drop;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [15:0] ref_lfsr(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_ph   = 1'b0;
    m_ovf  = 1'b0;
    m_wr   = 1'b0;
    m_cnt  = 16'h0000;
    m_lfsr = SEED;
    m_drop = 16'h0000;
    m_data = 16'h0000;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    if (!m_run) begin
      m_wr = 1'b0;
      if (enable) begin
        m_run  = 1'b1;
        m_cnt  = 16'h0000;
        m_lfsr = SEED;
        m_ph   = 1'b0;
      end
    end else begin
      case (mode)
        2'd0:    w = m_cnt;
        2'd1:    w = m_lfsr;
        2'd2:    w = const_word;
        default: w = m_ph ? 16'hAAAA : 16'h5555;
      endcase
      if (fifo_full) begin
        m_wr  = 1'b0;
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        m_wr   = 1'b1;
        m_data = w;
      end
      m_cnt  = m_cnt + 16'd1;
      m_lfsr = ref_lfsr(m_lfsr);
      m_ph   = ~m_ph;
      if (!enable) m_run = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_data);
    #1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_wr"},   fifo_wr_en, m_wr);
    chk({tag, "_data"}, fifo_wdata, m_data);
    chk({tag, "_drop"}, drop_count, m_drop);
    chk({tag, "_ovf"},  overflow,   m_ovf);
    chk({tag, "_busy"}, busy,       m_run);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    fifo_full = 1'b0;
    #1;
    model_reset();
    @(posedge clk_data);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] wq[$];
    int          first_edge;
    int          wr_seen;
    bit          zero_seen;

    // en, full -> expected wr, data, drop, ovf after the edge (mode 0)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0001, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0002, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0003, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h0008, 16'h0003, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0009, 16'h0003, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0009, 16'h0003, 1'b1};

    do_reset();
    chk("rst_wr",   fifo_wr_en, 1'b0);
    chk("rst_data", fifo_wdata, 16'h0000);
    chk("rst_drop", drop_count, 16'h0000);
    chk("rst_ovf",  overflow,   1'b0);
    chk("rst_busy", busy,       1'b0);

    // Full-flag gap after word 4
    mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      enable    = tbl[i].en;
      fifo_full = tbl[i].full;
      tick();
      chk($sformatf("tbl%0d_wr", i),   fifo_wr_en, tbl[i].exp_wr);
      chk($sformatf("tbl%0d_data", i), fifo_wdata, tbl[i].exp_data);
      chk($sformatf("tbl%0d_drop", i), drop_count, tbl[i].exp_drop);
      chk($sformatf("tbl%0d_ovf", i),  overflow,   tbl[i].exp_ovf);
    end

    // Ten enabled cycles give ten counter writes, first one edge after entering RUN
    do_reset();
    mode       = 2'd0;
    first_edge = -1;
    for (int k = 0; k < 13; k++) begin
      enable = (k < 10);
      tick();
      if (fifo_wr_en) begin
        if (first_edge < 0) first_edge = k;
        wq.push_back(fifo_wdata);
      end
    end
    chk("burst_first_edge", first_edge, 1);
    chk("burst_count", wq.size(), 10);
    for (int j = 0; j < wq.size(); j++) chk($sformatf("burst_word%0d", j), wq[j], j);

    // LFSR sequence from reset
    do_reset();
    mode      = 2'd1;
    enable    = 1'b1;
    zero_seen = 1'b0;
    tick();
    tick();
    chk("lfsr_first", {fifo_wr_en, fifo_wdata}, {1'b1, 16'hACE1});
    for (int k = 0; k < 999; k++) begin
      tick();
      model_check("lfsr");
      if (fifo_wr_en && fifo_wdata == 16'h0000) zero_seen = 1'b1;
    end
    chk("lfsr_nonzero", zero_seen, 1'b0);

    // Drop counter saturation
    do_reset();
    mode      = 2'd0;
    enable    = 1'b1;
    fifo_full = 1'b1;
    wr_seen   = 0;
    tick();
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (fifo_wr_en) wr_seen++;
      if (n == 65534) chk("sat_fffe", drop_count, 16'hFFFE);
      if (n == 65535) chk("sat_ffff", drop_count, 16'hFFFF);
    end
    chk("sat_hold", drop_count, 16'hFFFF);
    chk("sat_no_write", wr_seen, 0);
    model_check("sat");

    // Asynchronous reset in the middle of an alternating burst
    do_reset();
    mode      = 2'd3;
    enable    = 1'b1;
    fifo_full = 1'b0;
    tick();
    tick();
    chk("alt_w0", fifo_wdata, 16'h5555);
    tick();
    chk("alt_w1", fifo_wdata, 16'hAAAA);
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    tick();
    model_check("alt_pre_rst");
    rst = 1'b1;
    #2;
    chk("arst_wr",   fifo_wr_en, 1'b0);
    chk("arst_data", fifo_wdata, 16'h0000);
    chk("arst_drop", drop_count, 16'h0000);
    chk("arst_ovf",  overflow,   1'b0);
    chk("arst_busy", busy,       1'b0);
    model_reset();
    @(posedge clk_data);
    #1;
    rst = 1'b0;
    tick();
    chk("arst_no_extra_wr", fifo_wr_en, 1'b0);
    tick();
    chk("arst_w0", {fifo_wr_en, fifo_wdata}, {1'b1, 16'h5555});
    tick();
    chk("arst_w1", {fifo_wr_en, fifo_wdata}, {1'b1, 16'hAAAA});

    // Enable toggle restarts the counter but keeps the drop count
    do_reset();
    mode   = 2'd0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    fifo_full = 1'b1;
    tick();
    tick();
    fifo_full = 1'b0;
    enable    = 1'b0;
    tick();
    model_check("tog_fall");
    tick();
    chk("tog_idle_busy", busy, 1'b0);
    enable = 1'b1;
    tick();
    tick();
    chk("tog_restart", {fifo_wr_en, fifo_wdata}, {1'b1, 16'h0000});
    chk("tog_drop_kept", drop_count, 16'h0002);
    model_check("tog");

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      enable    = ($urandom_range(0, 15) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      const_word = DW'($urandom);
      tick();
      model_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
